// File: rtl/depacketizer_mvc_if.sv
// Flit-in / packet-out bundle for depacketizer_mvc.
// slave = depacketizer side, master = router/consumer side.
interface depacketizer_mvc_if #(
  parameter int WIDTH_FLIT       = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int MAX_FLITS        = 4,
  parameter int WIDTH_DATA       = 128
);
  localparam int NUM_VC = 1 << VC_ADDRESS_WIDTH;
  localparam int CNT_W  = $clog2(MAX_FLITS + 1);

  logic [WIDTH_FLIT-1:0]       flit_in;
  logic [NUM_VC-1:0]           ready_out;
  logic [WIDTH_DATA-1:0]       data_out;
  logic [VC_ADDRESS_WIDTH-1:0] vc_out;
  logic [CNT_W-1:0]            nflits_out;
  logic                        valid_out;
  logic                        ready_in;
  logic [7:0]                  err_count_out;

  modport slave (
    input  flit_in, ready_in,
    output ready_out, data_out, vc_out, nflits_out, valid_out, err_count_out
  );

  modport master (
    output flit_in, ready_in,
    input  ready_out, data_out, vc_out, nflits_out, valid_out, err_count_out
  );
endinterface

// File: rtl/depacketizer_mvc.sv
// Multi-VC, multi-flit depacketizer with round-robin packet output.
// Define DEPACKETIZER_PROTOCOL_CHECK_EN to enable the saturating protocol error counter.
module depacketizer_mvc #(
  parameter int WIDTH_FLIT       = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int MAX_FLITS        = 4,
  parameter int WIDTH_DATA       = 128
) (
  input logic               clk,
  input logic               rst_n,
  depacketizer_mvc_if.slave bus
);
  localparam int NUM_VC = 1 << VC_ADDRESS_WIDTH;
  localparam int P      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
  localparam int ASM_W  = MAX_FLITS * P;
  localparam int CNT_W  = $clog2(MAX_FLITS + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ASSEMBLE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  logic [1:0]                  state_q [NUM_VC];
  logic [1:0]                  state_d [NUM_VC];
  logic [CNT_W-1:0]            cnt_q   [NUM_VC];
  logic [CNT_W-1:0]            cnt_d   [NUM_VC];
  logic [ASM_W-1:0]            asm_q   [NUM_VC];
  logic [ASM_W-1:0]            asm_d   [NUM_VC];
  logic [VC_ADDRESS_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [VC_ADDRESS_WIDTH-1:0] lock_vc_q, lock_vc_d;
  logic                        lock_q, lock_d;

  logic                        f_valid, f_head, f_tail, accept, proto_err;
  logic [VC_ADDRESS_WIDTH-1:0] f_vc;
  logic [P-1:0]                f_payload;
  logic [NUM_VC-1:0]           ready_vec;
  logic                        any_done;
  logic [VC_ADDRESS_WIDTH-1:0] rr_sel, sel;

  assign f_valid   = bus.flit_in[WIDTH_FLIT-1];
  assign f_head    = bus.flit_in[WIDTH_FLIT-2];
  assign f_tail    = bus.flit_in[WIDTH_FLIT-3];
  assign f_vc      = bus.flit_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
  assign f_payload = bus.flit_in[P-1:0];

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) ready_vec[v] = (state_q[v] != ST_DONE);
  end

  assign accept = f_valid && ready_vec[f_vc];

  // Scan downward so the last hit is the first DONE VC at or after rr_ptr.
  always_comb begin
    any_done = 1'b0;
    rr_sel   = rr_ptr_q;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (state_q[rr_ptr_q + VC_ADDRESS_WIDTH'(i)] == ST_DONE) begin
        any_done = 1'b1;
        rr_sel   = rr_ptr_q + VC_ADDRESS_WIDTH'(i);
      end
    end
  end

  // A stalled output stays pinned so a later-completing VC cannot preempt it.
  assign sel = lock_q ? lock_vc_q : rr_sel;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    proto_err = 1'b0;

    if (any_done) begin
      if (bus.ready_in) begin
        state_d[sel] = ST_IDLE;
        rr_ptr_d     = sel + VC_ADDRESS_WIDTH'(1);
        lock_d       = 1'b0;
      end else begin
        lock_d    = 1'b1;
        lock_vc_d = sel;
      end
    end

    if (accept) begin
      if (f_head) begin
        proto_err              = (state_q[f_vc] == ST_ASSEMBLE);
        asm_d[f_vc]            = '0;
        asm_d[f_vc][ASM_W-1 -: P] = f_payload;
        cnt_d[f_vc]            = CNT_W'(1);
        state_d[f_vc]          = f_tail ? ST_DONE : ST_ASSEMBLE;
      end else if (state_q[f_vc] == ST_IDLE) begin
        proto_err = 1'b1;
      end else if (state_q[f_vc] == ST_ASSEMBLE) begin
        if (int'(cnt_q[f_vc]) < MAX_FLITS) begin
          asm_d[f_vc][ASM_W - 1 - int'(cnt_q[f_vc]) * P -: P] = f_payload;
          cnt_d[f_vc] = cnt_q[f_vc] + CNT_W'(1);
        end else begin
          proto_err = 1'b1;
        end
        if (f_tail) state_d[f_vc] = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the assembly storage is reset because unfilled slots must read as zero.
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v] <= ST_IDLE;
        cnt_q[v]   <= '0;
        asm_q[v]   <= '0;
      end
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
    end
  end

  assign bus.ready_out  = ready_vec;
  assign bus.valid_out  = any_done;
  assign bus.data_out   = any_done ? asm_q[sel][ASM_W-1 -: WIDTH_DATA] : '0;
  assign bus.vc_out     = any_done ? sel : '0;
  assign bus.nflits_out = any_done ? cnt_q[sel] : '0;

`ifdef DEPACKETIZER_PROTOCOL_CHECK_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (proto_err && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign bus.err_count_out = err_q;
`else
  logic unused_proto_err;
  assign unused_proto_err  = proto_err;
  assign bus.err_count_out = '0;
`endif
endmodule

// File: doc/depacketizer_mvc.md
# depacketizer_mvc

Parametrised multi-flit, multi-VC depacketizer: accepts a serial stream of NoC flits, reassembles up to MAX_FLITS flits per packet independently on each of 2^VC_ADDRESS_WIDTH virtual channels, and delivers each completed packet as one WIDTH_DATA word on a valid/ready output.
- Sits between a router output port and a module input.
- Generalises the fixed 1/2/4-flit depacketizers to any flit count, with interleaved-VC reassembly and round-robin output.

## Interface
- WIDTH_FLIT, 36: input flit width.
- VC_ADDRESS_WIDTH, 1: VC id bits. NUM_VC = 2^VC_ADDRESS_WIDTH.
- MAX_FLITS, 4: maximum flits per packet (≥1).
- WIDTH_DATA, 128: output data width. Must satisfy WIDTH_DATA ≤ MAX_FLITS*P, where P = WIDTH_FLIT-3-VC_ADDRESS_WIDTH.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flit_in  in  WIDTH_FLIT  flit fields:
  - [W-1] valid, [W-2] head, [W-3] tail.
  - [W-4 -: VC_ADDRESS_WIDTH] vc.
  - [P-1:0] payload.
- ready_out  out  NUM_VC  per-VC accept indication to the router.
- data_out  out  WIDTH_DATA  reassembled packet.
- vc_out  out  VC_ADDRESS_WIDTH  VC the packet arrived on.
- nflits_out  out  $clog2(MAX_FLITS+1)  flits in the packet.
- valid_out  out  1  packet available.
- ready_in  in  1  downstream accept.
- err_count_out  out  8  protocol error count (see Configuration).

## Operation
- Per-VC state: IDLE, ASSEMBLE, DONE.
- Each VC has an assembly register of MAX_FLITS*P bits and a flit counter.
- Flit accept: a flit is accepted when flit_in valid=1 and ready_out[vc]=1.
- ready_out[v] = 1 unless VC v is in DONE.
- Head flit accepted in IDLE:
  - Clears the assembly register, writes payload to slot 0 (most significant P bits), sets count=1.
  - Goes to DONE if tail=1, else ASSEMBLE.
- Body/tail flit accepted in ASSEMBLE with count<MAX_FLITS:
  - Writes payload to slot count, increments count.
  - Goes to DONE on tail=1.
- Head flit on a VC in ASSEMBLE: discards the partial packet and restarts as a head flit in IDLE.
- Non-head flit on a VC in IDLE: dropped.
- Flit arriving on a VC in ASSEMBLE with count==MAX_FLITS: dropped.
  - If that flit has tail=1, the VC still goes to DONE with MAX_FLITS flits.
- Output selection: round-robin over VCs in DONE, starting at rr_ptr.
  - valid_out = 1 when any VC is in DONE.
  - data_out = top WIDTH_DATA bits of the selected VC's assembly register.
  - vc_out and nflits_out come from the selected VC.
  - Output muxing is combinational from registered state.
- On valid_out & ready_in: the selected VC returns to IDLE and rr_ptr = selected+1 (mod NUM_VC).
- Unfilled slots read as zero.
- Reset state:
  - All VCs IDLE, counts 0, assembly registers 0, rr_ptr=0.
  - Outputs: ready_out all ones, valid_out=0, data_out=0, vc_out=0, nflits_out=0, err_count_out=0.

## Timing
- Latency: tail accepted at edge n -> valid_out=1 after edge n (visible in cycle n+1).
- Single-flit packet: same one-cycle latency.
- Throughput: one flit per cycle in; one packet per cycle out when ready_in is held high.
- VC v in DONE holds ready_out[v]=0 until drained.
- ready_out[v] rises the cycle after drain, so same-VC back-to-back packets incur one bubble.
- Other VCs keep accepting flits while one VC waits in DONE.
- valid_out with ready_in=0: data_out, vc_out, nflits_out are stable and the selection does not change.
  - Newly completing VCs do not preempt the current selection.
- Draining VC a and accepting a flit on VC b≠a in the same cycle are independent; both take effect.
- Reset asserted mid-packet: everything returns to reset state immediately (asynchronous); partial packets are lost.

## Configuration
- DEPACKETIZER_PROTOCOL_CHECK_EN defined:
  - err_count_out is an 8-bit saturating counter (stops at 255).
  - It increments by 1 per protocol event: head on ASSEMBLE, non-head on IDLE, flit dropped at count==MAX_FLITS.
  - It does not increment for a dropped flit on a DONE VC: such a flit is never accepted.
- DEPACKETIZER_PROTOCOL_CHECK_EN undefined:
  - err_count_out is tied to 0 and the counter logic is absent.
  - Datapath behaviour, including the drop and restart rules, is identical.

## Test plan
- Defaults; 4-flit packet on VC0 with payloads 1,2,3,4 -> one cycle after the tail: valid_out=1, vc_out=0, nflits_out=4, data_out top four P-bit slots = 1,2,3,4.
- Head+tail single flit on VC1 with payload 0xAB -> next cycle valid_out=1, vc_out=1, nflits_out=1, slot 0 = 0xAB, other slots 0.
- Interleave flits of a VC0 packet and a VC1 packet, both completing, ready_in=0 for 3 cycles, then 1:
  - Output VC0 then VC1; outputs stable while stalled.
  - ready_out[0] and ready_out[1] stay 0 until each VC drains.
- Head, body, then a new head with tail on VC0 (macro on) -> packet has nflits_out=1 with the second head's payload; err_count_out=1.
- 5 flits without tail, then tail, with MAX_FLITS=4 (macro on):
  - Packet has nflits_out=4 holding the first 4 payloads.
  - err_count_out=2: 5th flit and tail flit dropped.
- Deassert rst_n mid-packet on VC0 for 1 cycle -> all outputs at reset values; a subsequent fresh 2-flit packet reassembles correctly.
